// File: rtl/clock_display_pkg.sv
// Shared constants for the alarm clock display path.
package clock_display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int SEL_W      = 2;

  localparam int DEF_PRESCALE     = 50000;
  localparam int DEF_GUARD        = 16;
  localparam int DEF_BLINK_FRAMES = 125;

  // Counter width for a modulus n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_tick_div.sv
// Free-running prescaler: counts 0..PRESCALE-1 while enabled, tick on the last count.
module tick_div
  import clock_display_pkg::*;
#(
  parameter  int PRESCALE = DEF_PRESCALE,
  localparam int PW       = cnt_w(PRESCALE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [PW-1:0] pc,
  output logic          tick
);

  localparam logic [PW-1:0] PC_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pc_q, pc_d;

  assign pc   = pc_q;
  assign tick = en & (pc_q == PC_MAX);

  always_comb begin
    pc_d = pc_q;
    if (clr)
      pc_d = '0;
    else if (en)
      pc_d = tick ? '0 : pc_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// 4-digit 7-segment scan controller: frame-stable digit snapshot, blanking,
// blinking and a per-slot anode guard interval.
module display_scan_ctrl
  import clock_display_pkg::*;
#(
  parameter int PRESCALE     = DEF_PRESCALE,
  parameter int GUARD        = DEF_GUARD,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  input  logic [NUM_DIGITS-1:0]         blank,
  input  logic [NUM_DIGITS-1:0]         blink,
  output logic [SEL_W-1:0]              sel,
  output logic                          sel_en,
  output logic [DIGIT_W-1:0]            bcd,
  output logic                          frame_done
);

  localparam int PW = cnt_w(PRESCALE);
  localparam int BW = cnt_w(BLINK_FRAMES);
  localparam logic [PW-1:0] GUARD_C = PW'(GUARD);
  localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_FRAMES - 1);

  logic                          en_q, en_d;
  logic [SEL_W-1:0]              sel_q, sel_d;
  logic [NUM_DIGITS*DIGIT_W-1:0] dig_s_q, dig_s_d;
  logic [NUM_DIGITS-1:0]         blank_s_q, blank_s_d;
  logic [NUM_DIGITS-1:0]         blink_s_q, blink_s_d;
  logic [BW-1:0]                 bcnt_q, bcnt_d;
  logic                          bphase_q, bphase_d;
  logic                          frame_done_q, frame_done_d;

  logic [PW-1:0] pc;
  logic          tick;
  logic          frame_end;
  logic          load_snap;

  tick_div #(.PRESCALE(PRESCALE)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (~en_q),
    .en    (en_q),
    .pc    (pc),
    .tick  (tick)
  );

  assign frame_end = tick & (sel_q == SEL_W'(NUM_DIGITS - 1));
  // Snapshots track the inputs while idle so the first frame shows fresh data.
  assign load_snap = ~en_q | frame_end;

  always_comb begin
    en_d         = en;
    sel_d        = sel_q;
    dig_s_d      = dig_s_q;
    blank_s_d    = blank_s_q;
    blink_s_d    = blink_s_q;
    bcnt_d       = bcnt_q;
    bphase_d     = bphase_q;
    frame_done_d = frame_end;

    if (!en_q)
      sel_d = '0;
    else if (tick)
      sel_d = sel_q + SEL_W'(1);

    if (load_snap) begin
      dig_s_d   = digits;
      blank_s_d = blank;
      blink_s_d = blink;
    end

    if (frame_end) begin
      if (bcnt_q == BCNT_MAX) begin
        bcnt_d   = '0;
        bphase_d = ~bphase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q         <= 1'b0;
      sel_q        <= '0;
      dig_s_q      <= '0;
      blank_s_q    <= '0;
      blink_s_q    <= '0;
      bcnt_q       <= '0;
      bphase_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      en_q         <= en_d;
      sel_q        <= sel_d;
      dig_s_q      <= dig_s_d;
      blank_s_q    <= blank_s_d;
      blink_s_q    <= blink_s_d;
      bcnt_q       <= bcnt_d;
      bphase_q     <= bphase_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Gating sel with en_q returns the decoder to digit 0 the moment scanning stops.
  assign sel        = en_q ? sel_q : '0;
  assign bcd        = dig_s_q[{sel, 2'b00} +: DIGIT_W];
  assign sel_en     = en_q & (pc >= GUARD_C) & ~blank_s_q[sel] & ~(bphase_q & blink_s_q[sel]);
  assign frame_done = frame_done_q;

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller for the alarm clock's 4-digit 7-segment display. It cycles a 2-bit digit index at a fixed refresh rate and selects the matching BCD digit from a frame-stable snapshot of the time/alarm value. It applies per-digit blanking, blinking (set mode) and an anti-ghosting guard interval. Its `sel`/`sel_en` outputs feed the downstream 2-to-4 anode decoder's `In`/`en` inputs; `bcd` feeds the BCD-to-segment decoder.

## Interface
Parameters:
- `PRESCALE`, 50000: clocks per digit slot; minimum 4.
- `GUARD`, 16: clocks at the start of each slot with anodes off; must satisfy 1 ≤ GUARD < PRESCALE.
- `BLINK_FRAMES`, 125: full frames (4 slots each) per blink half-period; minimum 1.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `en`  in  1  display enable.
- `digits`  in  16  four BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- `blank`  in  4  per-digit blank mask; 1 = digit always off.
- `blink`  in  4  per-digit blink mask; 1 = digit off during the blink-off phase.
- `sel`  out  2  digit index to the anode decoder.
- `sel_en`  out  1  anode enable to the anode decoder.
- `bcd`  out  4  BCD value of the selected digit.
- `frame_done`  out  1  one-cycle pulse at the end of each 4-slot frame.

## Operation
- `en_q` is `en` registered. All outputs are functions of registers only; there is no input-to-output combinational path.
- `en_q`=0 (idle):
  - `pc`<=0 and `sel`<=0.
  - Snapshot registers `dig_s`, `blank_s`, `blink_s` load `digits`, `blank`, `blink` every cycle.
  - Blink counter and phase hold.
  - `sel_en`=0.
- `en_q`=1 (scan):
  - `pc` counts 0..PRESCALE-1 and wraps.
  - `tick` = (`pc`==PRESCALE-1).
  - On `tick`, `sel`<=`sel`+1, wrapping 3→0.
- Frame end is `tick` with `sel`==3. On frame end:
  - Snapshots reload from the inputs.
  - `frame_done`<=1 for one cycle.
  - `bcnt` increments. When `bcnt`==BLINK_FRAMES-1, `bcnt`<=0 and `bphase` toggles. `bphase`=1 means blink-off.
- Inputs changing mid-frame have no visible effect until the next frame end.
- `bcd` = `dig_s[4*sel+3 : 4*sel]`. `bcd` is valid whenever `en_q`=1, regardless of masks.
- `sel_en` = `en_q` & (`pc` ≥ GUARD) & ~`blank_s[sel]` & ~(`bphase` & `blink_s[sel]`). `blank` overrides `blink`.
- BCD values above 9 pass through unchanged; segment decoding is downstream.

## Timing
- Reset values: `sel`=0, `sel_en`=0, `bcd`=0, `frame_done`=0. All internal registers (`pc`, `bcnt`, `bphase`, snapshots, `en_q`) are 0.
- Async assertion of `rst_n` clears all outputs immediately, without a clock edge. After release, scanning restarts from slot 0, `bphase`=0.
- Enable latency: `en` rises at edge N, so `en_q`=1 after edge N+1. `sel_en` first goes high when `pc`==GUARD, i.e. GUARD cycles after `en_q` rises.
- Slot duration is exactly PRESCALE cycles. Per slot, `sel_en` is low for GUARD cycles, then high for PRESCALE-GUARD cycles unless masked.
- `sel` and `bcd` change in the same cycle. `sel_en` is always 0 on the first cycle of a new `sel`, so there is no ghosting.
- Frame period is 4·PRESCALE cycles. The blink full period is 2·BLINK_FRAMES frames.
- `en` falling: after `en_q` falls, `sel_en` is 0 that same cycle and `sel` returns to 0. A partial frame does not generate `frame_done` and does not advance `bcnt`.
- `frame_done` is asserted in the cycle after the wrapping `tick`, together with `sel`=0.

## Structure
- Shared package `clock_display_pkg`:
  - `NUM_DIGITS`=4, `DIGIT_W`=4, `SEL_W`=2.
  - `DEF_PRESCALE`, `DEF_GUARD`, `DEF_BLINK_FRAMES`.
- Counter widths are $clog2 of the respective parameter.
- One sub-module is natural: `tick_div` (PRESCALE counter with sync clear, outputs `pc` and `tick`), reusable by the seconds timebase.

## Test plan
Bench parameters: PRESCALE=8, GUARD=2, BLINK_FRAMES=2.
- Basic scan: reset, then `en`=1, `digits`=16'h1234, masks 0 → `sel`/`bcd` step through 0/4, 1/3, 2/2, 3/1, 8 cycles each. `sel_en` is low for the first 2 cycles of each slot. `frame_done` pulses every 32 cycles.
- Frame-stable snapshot: change `digits` to 16'h5678 while `sel`==1 → remainder of the frame shows 3,2,1; next frame shows 8,7,6,5.
- Blank mask: `blank`=4'b1000 → `sel_en` never 1 while `sel`==3; other slots unaffected.
- Blink mask: `blink`=4'b0011 → digits 0–1 are enabled in frames 0–1, disabled in frames 2–3, enabled in frames 4–5. With `blank`=`blink`=4'b0001, digit 0 is never enabled.
- Async reset mid-scan: drop `rst_n` between edges while `sel`==2 → all outputs 0 before the next edge. After release with `en`=1, the scan restarts at `sel`=0 with `bphase`=0.
- Enable drop mid-frame: deassert `en` at `sel`==2 → one edge later `sel`=0 and `sel_en`=0; no `frame_done` pulse; `bcnt` unchanged. Re-enable → full GUARD delay before `sel_en`.
